// File: rtl/ttl_nand_st_filter_pkg.sv
// Shared definitions for the NAND Schmitt-trigger filter: defaults, counter sizing
// and the per-channel state names.
package ttl_filter_pkg;

    localparam int   FILTER_DEF  = 3;
    localparam logic RST_VAL_DEF = 1'b1;

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_QUAL   = 1'b1
    } chan_state_e;

    // Width needed to hold counts 0..filter, never narrower than one bit.
    function automatic int cnt_width(input int filter);
        int w;
        w = $clog2(filter + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ttl_nand_st_filter_if.sv
// Bus bundle for ttl_nand_st_filter: sample strobe, gate inputs and filtered outputs.
// TTL_NAND_ST_EDGE_EN adds the rise/fall pulse outputs.
interface ttl_nand_st_filter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] busy;
`ifdef TTL_NAND_ST_EDGE_EN
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    modport master (output en, a, b, input y, busy, rise, fall);
    modport slave  (input en, a, b, output y, busy, rise, fall);
`else
    modport master (output en, a, b, input y, busy);
    modport slave  (input en, a, b, output y, busy);
`endif
endinterface

// File: rtl/ttl_nand_st_filter_chan.sv
// One filter channel: sample register, stability counter and filtered output.
// TTL_NAND_ST_EDGE_EN adds registered rise/fall pulses on each output commit.
module ttl_st_chan
    import ttl_filter_pkg::*;
#(
    parameter int   FILTER  = FILTER_DEF,
    parameter logic RST_VAL = RST_VAL_DEF
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    input  logic raw,
    output logic y,
    output logic busy
`ifdef TTL_NAND_ST_EDGE_EN
    ,
    output logic rise,
    output logic fall
`endif
);

    // A filter length below one behaves as one.
    localparam int FILT_EFF = (FILTER < 1) ? 1 : FILTER;
    localparam int CNT_W    = cnt_width(FILT_EFF);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_EFF - 1);

    logic             s_q, s_d;
    logic             y_q, y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    chan_state_e      state;

    always_comb begin
        s_d   = s_q;
        y_d   = y_q;
        cnt_d = cnt_q;
        if (en) begin
            s_d = raw;
            if (s_q == y_q) begin
                // Sample agrees with the output again: drop any pending change.
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                y_d   = s_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            s_q   <= RST_VAL;
            y_q   <= RST_VAL;
            cnt_q <= '0;
        end else begin
            s_q   <= s_d;
            y_q   <= y_d;
            cnt_q <= cnt_d;
        end
    end

    assign state = ((cnt_q == '0) && (s_q == y_q)) ? ST_STABLE : ST_QUAL;

    always_ff @(posedge clk) begin
        if (!clr) begin
            assert (cnt_q <= CNT_LAST);
            assert (!(cnt_q != '0 && state == ST_STABLE));
        end
    end

    assign y    = y_q;
    assign busy = (cnt_q != '0);

`ifdef TTL_NAND_ST_EDGE_EN
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    // Pulses line up with the first cycle in which y shows its new level.
    always_comb begin
        rise_d = y_d & ~y_q;
        fall_d = ~y_d & y_q;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`endif

endmodule

// File: rtl/ttl_nand_st_filter.sv
// Multi-channel 2-input NAND with clocked time-domain hysteresis per channel.
// Define TTL_NAND_ST_EDGE_EN to get per-channel rise/fall commit pulses.
module ttl_nand_st_filter
    import ttl_filter_pkg::*;
#(
    parameter int   WIDTH   = 4,
    parameter int   FILTER  = FILTER_DEF,
    parameter logic RST_VAL = RST_VAL_DEF
) (
    input  logic                  clk,
    input  logic                  clr,
    ttl_nand_st_filter_if.slave   bus
);

    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] y_w;
    logic [WIDTH-1:0] busy_w;
`ifdef TTL_NAND_ST_EDGE_EN
    logic [WIDTH-1:0] rise_w;
    logic [WIDTH-1:0] fall_w;
`endif

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
            assign raw[gi] = ~(bus.a[gi] & bus.b[gi]);

            ttl_st_chan #(
                .FILTER  (FILTER),
                .RST_VAL (RST_VAL)
            ) u_chan (
                .clk  (clk),
                .clr  (clr),
                .en   (bus.en),
                .raw  (raw[gi]),
                .y    (y_w[gi]),
                .busy (busy_w[gi])
`ifdef TTL_NAND_ST_EDGE_EN
                ,
                .rise (rise_w[gi]),
                .fall (fall_w[gi])
`endif
            );
        end
    endgenerate

    assign bus.y    = y_w;
    assign bus.busy = busy_w;
`ifdef TTL_NAND_ST_EDGE_EN
    assign bus.rise = rise_w;
    assign bus.fall = fall_w;
`endif

endmodule

// File: tb/tb_ttl_nand_st_filter.sv
// Bench for ttl_nand_st_filter: FILTER=3 and FILTER=1 instances share stimulus and
// are compared each edge against a sample-history model of the qualification rule.
module tb_ttl_nand_st_filter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         clr;
    logic         en_drv;
    logic [W-1:0] a_drv, b_drv;

    always #5 clk = ~clk;

    ttl_nand_st_filter_if #(.WIDTH(W)) bus3 ();
    ttl_nand_st_filter_if #(.WIDTH(W)) bus1 ();

    assign bus3.en = en_drv;
    assign bus3.a  = a_drv;
    assign bus3.b  = b_drv;
    assign bus1.en = en_drv;
    assign bus1.a  = a_drv;
    assign bus1.b  = b_drv;

    ttl_nand_st_filter #(.WIDTH(W), .FILTER(3), .RST_VAL(1'b1)) dut3 (
        .clk (clk),
        .clr (clr),
        .bus (bus3.slave)
    );

    ttl_nand_st_filter #(.WIDTH(W), .FILTER(1), .RST_VAL(1'b1)) dut1 (
        .clk (clk),
        .clr (clr),
        .bus (bus1.slave)
    );

    int checks = 0;
    int errors = 0;

    // Model: per config k (0: FILTER=3, 1: FILTER=1) and channel i.
    int          filt [2];
    logic        m_s    [2][W];
    logic        m_y    [2][W];
    logic        m_rise [2][W];
    logic        m_fall [2][W];
    logic [31:0] hist   [2][W];
    int          nval   [2][W];

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Output changes once the last FILTER enabled samples all disagree with it.
    task automatic model_edge();
        logic [W-1:0] raw;
        logic [31:0]  mask;
        logic [31:0]  want;
        raw = ~(a_drv & b_drv);
        for (int k = 0; k < 2; k++) begin
            mask = (32'd1 << filt[k]) - 32'd1;
            for (int i = 0; i < W; i++) begin
                m_rise[k][i] = 1'b0;
                m_fall[k][i] = 1'b0;
                if (clr) begin
                    m_s[k][i]  = 1'b1;
                    m_y[k][i]  = 1'b1;
                    hist[k][i] = '0;
                    nval[k][i] = 0;
                end else if (en_drv) begin
                    hist[k][i] = {hist[k][i][30:0], m_s[k][i]};
                    if (nval[k][i] < 32) nval[k][i]++;
                    want = m_y[k][i] ? 32'd0 : mask;
                    if (nval[k][i] >= filt[k] && (hist[k][i] & mask) == want) begin
                        m_y[k][i]    = ~m_y[k][i];
                        m_rise[k][i] = m_y[k][i];
                        m_fall[k][i] = ~m_y[k][i];
                    end
                    m_s[k][i] = raw[i];
                end
            end
        end
    endtask

    // Pending qualification = trailing samples that disagree with the output.
    function automatic logic [W-1:0] exp_busy(input int k);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) begin
            r[i] = (nval[k][i] > 0) && (hist[k][i][0] == ~m_y[k][i]);
        end
        return r;
    endfunction

    function automatic logic [W-1:0] exp_y(input int k);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = m_y[k][i];
        return r;
    endfunction

`ifdef TTL_NAND_ST_EDGE_EN
    function automatic logic [W-1:0] exp_rise(input int k);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = m_rise[k][i];
        return r;
    endfunction

    function automatic logic [W-1:0] exp_fall(input int k);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = m_fall[k][i];
        return r;
    endfunction
`endif

    task automatic step(input logic c, input logic e, input logic [W-1:0] av, input logic [W-1:0] bv);
        @(negedge clk);
        clr    = c;
        en_drv = e;
        a_drv  = av;
        b_drv  = bv;
        @(posedge clk);
        model_edge();
        #1;
        check("y_f3", bus3.y, exp_y(0));
        check("busy_f3", bus3.busy, exp_busy(0));
        check("y_f1", bus1.y, exp_y(1));
        check("busy_f1", bus1.busy, exp_busy(1));
`ifdef TTL_NAND_ST_EDGE_EN
        check("rise_f3", bus3.rise, exp_rise(0));
        check("fall_f3", bus3.fall, exp_fall(0));
        check("rise_f1", bus1.rise, exp_rise(1));
        check("fall_f1", bus1.fall, exp_fall(1));
        check("rise_and_fall", bus3.rise & bus3.fall, 4'h0);
`endif
        $display("t=%0t clr=%b en=%b a=%h b=%h | f3 y=%h busy=%h | f1 y=%h busy=%h",
                 $time, c, e, av, bv, bus3.y, bus3.busy, bus1.y, bus1.busy);
    endtask

    task automatic steps(input int n, input logic e, input logic [W-1:0] av, input logic [W-1:0] bv);
        for (int j = 0; j < n; j++) step(1'b0, e, av, bv);
    endtask

    initial begin
        logic [W-1:0] lvl;
        logic [W-1:0] ra, rb;
        filt[0] = 3;
        filt[1] = 1;
        clr = 1'b1; en_drv = 1'b1; a_drv = '1; b_drv = '1;

        // Reset with all gates driven low.
        step(1'b1, 1'b1, 4'hF, 4'hF);
        step(1'b1, 1'b1, 4'hF, 4'hF);
        check("rst_y", bus3.y, 4'hF);
        check("rst_busy", bus3.busy, 4'h0);
        step(1'b0, 1'b1, 4'hF, 4'hF);
        step(1'b0, 1'b1, 4'hF, 4'hF);
        check("f1_two_edges", bus1.y, 4'h0);
        check("busy_edge2", bus3.busy, 4'hF);
        step(1'b0, 1'b1, 4'hF, 4'hF);
        check("hold_edge3", bus3.y, 4'hF);
        step(1'b0, 1'b1, 4'hF, 4'hF);
        check("commit_edge4", bus3.y, 4'h0);
        check("busy_clear", bus3.busy, 4'h0);

        // Return all channels high.
        steps(6, 1'b1, 4'h0, 4'h0);
        check("all_high", bus3.y, 4'hF);

        // Two-sample glitch on ch0 must not reach y.
        steps(2, 1'b1, 4'h1, 4'h1);
        steps(4, 1'b1, 4'h0, 4'h0);
        check("glitch_y", bus3.y, 4'hF);

        // Enable hold on ch1 with cnt=1.
        steps(2, 1'b1, 4'h2, 4'h2);
        steps(5, 1'b0, 4'h2, 4'h2);
        check("hold_busy", bus3.busy, 4'h2);
        check("hold_y", bus3.y, 4'hF);
        steps(1, 1'b1, 4'h2, 4'h2);
        check("resume1_y", bus3.y, 4'hF);
        steps(1, 1'b1, 4'h2, 4'h2);
        check("resume2_y", bus3.y, 4'hD);
        steps(6, 1'b1, 4'h0, 4'h0);

        // Reset in the middle of ch2 qualification.
        steps(3, 1'b1, 4'h4, 4'h4);
        step(1'b1, 1'b1, 4'h4, 4'h4);
        check("midrst_y", bus3.y, 4'hF);
        check("midrst_busy", bus3.busy, 4'h0);
        steps(3, 1'b1, 4'h4, 4'h4);
        check("requal3_y", bus3.y, 4'hF);
        steps(1, 1'b1, 4'h4, 4'h4);
        check("requal4_y", bus3.y, 4'hB);
        steps(6, 1'b1, 4'h0, 4'h0);

        // ch3 toggles with 6-edge phases.
        for (int r = 0; r < 2; r++) begin
            steps(6, 1'b1, 4'h8, 4'h8);
            steps(6, 1'b1, 4'h0, 4'h0);
        end

        // Randomised slow/bouncing levels with occasional hold and reset.
        lvl = '0;
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < W; i++) begin
                if ($urandom_range(0, 4) == 0) lvl[i] = ~lvl[i];
                ra[i] = lvl[i] ? 1'b1 : 1'($urandom_range(0, 1));
                rb[i] = lvl[i];
            end
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) != 0), ra, rb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
